matmul_job_sequencer: RTL and testbench

//  Bus initiator that drives the matmul register-file slave port.
//  Per job it streams MAX_DIM operand-A rows and MAX_DIM operand-B rows into the slave,

---
 rtl/matmul_job_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_matmul_job_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_sequencer.sv
// Bus initiator that runs one matmul job: operand row load, start, poll, scratchpad drain.
// Optional poll timeout abort is compiled in when MATMUL_SEQ_TIMEOUT_EN is defined.
module matmul_job_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            job_valid_i,
  output logic                            job_ready_o,
  input  logic [15:0]                     job_ctrl_i,
  input  logic                            src_valid_i,
  output logic                            src_ready_o,
  input  logic [BUS_WIDTH-1:0]            src_data_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [BUS_WIDTH-1:0]            res_data_o,
  output logic                            res_last_o,
  output logic                            busy_o,
  output logic                            error_o,
  output logic [ADDR_WIDTH-1:0]           address_o,
  output logic [BUS_WIDTH-1:0]            data_o,
  output logic                            write_enable_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] strobe_o,
  input  logic [BUS_WIDTH-1:0]            data_i
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int ROW_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int IDX_W   = 2 * ROW_W;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAX_DIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_DIM * MAX_DIM - 1);

  localparam logic [4:0] REG_CONTROL = 5'h00;
  localparam logic [4:0] REG_OPA     = 5'h04;
  localparam logic [4:0] REG_OPB     = 5'h0C;
  localparam logic [4:0] REG_SP      = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_POLL   = 3'd4,
    S_READ   = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            ctrl_q, ctrl_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [MAX_DIM-1:0]     strobe_q, strobe_d;
  logic                   res_valid_q, res_valid_d;
  logic [BUS_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   res_last_q, res_last_d;
  logic                   error_q, error_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int PCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [PCNT_W-1:0]      poll_cnt_q, poll_cnt_d;
`endif

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [4:0] sel,
                                                     input logic [IDX_W-1:0] index);
    reg_addr = ADDR_WIDTH'(sel) | (ADDR_WIDTH'(index) << 5);
  endfunction

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    row_d       = row_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    error_d     = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif
    job_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    // A pending row write blocks the next row, capping load at one row per two cycles.
    src_ready_o = ((state_q == S_LOAD_A) || (state_q == S_LOAD_B)) && !we_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid_i && job_ready_o) begin
          ctrl_d  = job_ctrl_i;
          row_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (src_valid_i && src_ready_o) begin
          we_d    = 1'b1;
          addr_d  = reg_addr((state_q == S_LOAD_A) ? REG_OPA : REG_OPB, IDX_W'(row_q));
          wdata_d = src_data_i;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_START: begin
        // Wait out the last operand write so strobes never run back to back.
        if (!we_q) begin
          we_d    = 1'b1;
          addr_d  = reg_addr(REG_CONTROL, '0);
          wdata_d = BUS_WIDTH'(ctrl_q | 16'h0001);
          state_d = S_POLL;
`ifdef MATMUL_SEQ_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      S_POLL: begin
        // address_o already holds CONTROL from the start write; sample once it has settled.
        if (!we_q) begin
          if (!data_i[0]) begin
            idx_d   = '0;
            addr_d  = reg_addr(REG_SP, '0);
            state_d = S_READ;
          end else begin
`ifdef MATMUL_SEQ_TIMEOUT_EN
            if (poll_cnt_q == PCNT_W'(TIMEOUT_CYCLES - 1)) begin
              we_d    = 1'b1;
              addr_d  = reg_addr(REG_CONTROL, '0);
              wdata_d = '0;
              error_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              poll_cnt_d = poll_cnt_q + 1'b1;
            end
`endif
          end
        end
      end
      S_READ: begin
        res_data_d  = data_i;
        res_valid_d = 1'b1;
        res_last_d  = (idx_q == IDX_LAST);
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = reg_addr(REG_SP, idx_d);
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    strobe_d = {MAX_DIM{we_d}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      strobe_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      error_q     <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      strobe_q    <= strobe_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      error_q     <= error_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign address_o      = addr_q;
  assign data_o         = wdata_q;
  assign write_enable_o = we_q;
  assign strobe_o       = strobe_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_last_o     = res_last_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Randomized self-checking bench for matmul_job_sequencer with a behavioural slave and job model.
`timescale 1ns/1ps
module tb_matmul_job_sequencer;
  localparam int DW = 32, BW = 64, AW = 32, MD = BW / DW;
  localparam int NROWS = 2 * MD, NEL = MD * MD, TMO = 8;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          job_valid_i, job_ready_o;
  logic [15:0]   job_ctrl_i;
  logic          src_valid_i, src_ready_o;
  logic [BW-1:0] src_data_i;
  logic          res_valid_o, res_ready_i, res_last_o;
  logic [BW-1:0] res_data_o;
  logic          busy_o, error_o, write_enable_o;
  logic [AW-1:0] address_o;
  logic [BW-1:0] data_o, data_i;
  logic [MD-1:0] strobe_o;

  always #5 clk_i = ~clk_i;

  matmul_job_sequencer #(
    .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_ctrl_i(job_ctrl_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_last_o(res_last_o), .busy_o(busy_o), .error_o(error_o),
    .address_o(address_o), .data_o(data_o), .write_enable_o(write_enable_o),
    .strobe_o(strobe_o), .data_i(data_i)
  );

  int total = 0, bad = 0;
  logic [BW-1:0] rows [NROWS];
  logic [BW-1:0] sp_mem [NEL];
  int busy_polls = 0;

  // Slave: a start write arms the engine; it reports busy for busy_polls CONTROL reads.
  int slave_reads;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slave_reads <= 0;
    else if (write_enable_o && address_o == '0 && data_o[0]) slave_reads <= 0;
    else if (busy_o && !write_enable_o && address_o == '0) slave_reads <= slave_reads + 1;
  end

  always_comb begin
    data_i = '0;
    if (address_o[4:0] == 5'h00) begin
      data_i[BW-1:32] = 32'hC0DE0000;
      data_i[0] = (slave_reads < busy_polls);
    end else if (address_o[4:0] == 5'h10) begin
      data_i = sp_mem[address_o[6:5]];
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    logic [MD-1:0] s;
  } wr_t;
  wr_t           wr_q [$];
  logic [AW-1:0] sp_addr_q [$];
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            b2b = 0;

  always @(negedge clk_i) begin
    if (write_enable_o) wr_q.push_back(wr_t'({address_o, data_o, strobe_o}));
    if (address_o != prev_addr && address_o[4:0] == 5'h10) sp_addr_q.push_back(address_o);
    if (write_enable_o && prev_we) b2b <= b2b + 1;
    prev_we   <= write_enable_o;
    prev_addr <= address_o;
  end

  // mode 0: valid always high, 1: valid toggles each cycle, 2: random valid
  task automatic feed_rows(input int count, input int mode, output int fed);
    bit hs = 1'b0;
    fed = 0;
    for (int cyc = 0; cyc < 300 && fed < count; cyc++) begin
      @(negedge clk_i);
      if (hs) fed++;
      if (fed < count) begin
        case (mode)
          0:       src_valid_i = 1'b1;
          1:       src_valid_i = (cyc % 2 == 0);
          default: src_valid_i = ($urandom_range(0, 1) == 1);
        endcase
        src_data_i = rows[fed];
      end else begin
        src_valid_i = 1'b0;
        src_data_i  = {$urandom, $urandom};
      end
      hs = src_valid_i && src_ready_o;
    end
    src_valid_i = 1'b0;
  endtask

  task automatic do_job(input logic [15:0] ctrl, input int mode, input int gap,
                        input bit hold_ready, input bit noise);
    int wbase, abase, bbase, fed, n;
    logic [BW-1:0] held;
    wbase = wr_q.size(); abase = sp_addr_q.size(); bbase = b2b;
    @(negedge clk_i);
    total++;
    if (job_ready_o !== 1'b1) begin bad++; $display("FAIL job_ready_idle got=%b want=1", job_ready_o); end
    job_valid_i = 1'b1; job_ctrl_i = ctrl;
    @(negedge clk_i);
    job_valid_i = 1'b0; job_ctrl_i = 16'($urandom);
    total++;
    if (busy_o !== 1'b1 || job_ready_o !== 1'b0) begin
      bad++; $display("FAIL job_accept busy=%b ready=%b want 1/0", busy_o, job_ready_o);
    end
    res_ready_i = hold_ready;
    feed_rows(NROWS, mode, fed);
    total++;
    if (fed != NROWS) begin bad++; $display("FAIL feed_rows got=%0d want=%0d", fed, NROWS); end
    if (noise) begin
      for (int i = 0; i < 6; i++) begin
        job_valid_i = 1'b1; src_valid_i = 1'b1; src_data_i = {$urandom, $urandom};
        total++;
        if (src_ready_o !== 1'b0 || job_ready_o !== 1'b0) begin
          bad++; $display("FAIL busy_ignore src_ready=%b job_ready=%b want 0/0", src_ready_o, job_ready_o);
        end
        @(negedge clk_i);
      end
      job_valid_i = 1'b0; src_valid_i = 1'b0;
    end
    for (int e = 0; e < NEL; e++) begin
      n = 0;
      while (res_valid_o !== 1'b1 && n < 400) begin @(negedge clk_i); n++; end
      total++;
      if (res_valid_o !== 1'b1) begin
        bad++; $display("FAIL res_timeout elem=%0d valid=%b want=1", e, res_valid_o); break;
      end
      total++;
      if (res_data_o !== sp_mem[e]) begin
        bad++; $display("FAIL res_data elem=%0d got=%h want=%h", e, res_data_o, sp_mem[e]);
      end
      total++;
      if (res_last_o !== (e == NEL - 1)) begin
        bad++; $display("FAIL res_last elem=%0d got=%b want=%b", e, res_last_o, (e == NEL - 1));
      end
      held = res_data_o;
      if (!hold_ready) begin
        repeat (gap) begin
          @(negedge clk_i);
          total++;
          if (res_valid_o !== 1'b1 || res_data_o !== held || res_last_o !== (e == NEL - 1)) begin
            bad++; $display("FAIL res_hold elem=%0d valid=%b data=%h want 1/%h", e, res_valid_o, res_data_o, held);
          end
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
    end
    res_ready_i = 1'b0;
    total++;
    if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      bad++; $display("FAIL job_done ready=%b busy=%b valid=%b want 1/0/0", job_ready_o, busy_o, res_valid_o);
    end
    total++;
    if (wr_q.size() != wbase + NROWS + 1) begin
      bad++; $display("FAIL wr_count got=%0d want=%0d", wr_q.size() - wbase, NROWS + 1);
    end else begin
      for (int r = 0; r <= NROWS; r++) begin
        logic [AW-1:0] ea;
        logic [BW-1:0] ed;
        if (r < NROWS) begin
          ea = ((r / MD) == 0 ? 32'h04 : 32'h0C) + 32'(32 * (r % MD));
          ed = rows[r];
        end else begin
          ea = '0;
          ed = {48'b0, ctrl[15:1], 1'b1};
        end
        total++;
        if (wr_q[wbase + r].a !== ea || wr_q[wbase + r].d !== ed || wr_q[wbase + r].s !== {MD{1'b1}}) begin
          bad++; $display("FAIL wr_%0d got=(%h,%h,%b) want=(%h,%h,%b)", r, wr_q[wbase + r].a,
                          wr_q[wbase + r].d, wr_q[wbase + r].s, ea, ed, {MD{1'b1}});
        end
      end
    end
    total++;
    if (slave_reads != busy_polls + 1) begin
      bad++; $display("FAIL poll_reads got=%0d want=%0d", slave_reads, busy_polls + 1);
    end
    total++;
    if (sp_addr_q.size() != abase + NEL) begin
      bad++; $display("FAIL sp_addr_count got=%0d want=%0d", sp_addr_q.size() - abase, NEL);
    end else begin
      for (int e = 0; e < NEL; e++) begin
        total++;
        if (sp_addr_q[abase + e] !== AW'(32'h10 + 32 * e)) begin
          bad++; $display("FAIL sp_addr_%0d got=%h want=%h", e, sp_addr_q[abase + e], AW'(32'h10 + 32 * e));
        end
      end
    end
    total++;
    if (b2b != bbase) begin bad++; $display("FAIL wr_back_to_back got=%0d want=0", b2b - bbase); end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NROWS; i++) rows[i] = {$urandom, $urandom};
    for (int i = 0; i < NEL; i++) sp_mem[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({job_ready_o, src_ready_o, res_valid_o, res_last_o, busy_o, error_o, write_enable_o} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags got=%b want=1000000",
                      {job_ready_o, src_ready_o, res_valid_o, res_last_o, busy_o, error_o, write_enable_o});
    end
    total++;
    if (address_o !== '0 || data_o !== '0 || strobe_o !== '0 || res_data_o !== '0) begin
      bad++; $display("FAIL reset_buses addr=%h data=%h strb=%b res=%h want 0", address_o, data_o, strobe_o, res_data_o);
    end
    rst_ni = 1'b1;
    src_valid_i = 1'b1; res_ready_i = 1'b1; src_data_i = {$urandom, $urandom};
    repeat (3) @(negedge clk_i);
    total++;
    if (src_ready_o !== 1'b0 || write_enable_o !== 1'b0 || res_valid_o !== 1'b0 || job_ready_o !== 1'b1) begin
      bad++; $display("FAIL idle_ignore src_ready=%b we=%b valid=%b job_ready=%b want 0/0/0/1",
                      src_ready_o, write_enable_o, res_valid_o, job_ready_o);
    end
    src_valid_i = 1'b0; res_ready_i = 1'b0;
  endtask

  task automatic test_directed();
    rows[0] = 64'hA0; rows[1] = 64'hA1; rows[2] = 64'hB0; rows[3] = 64'hB1;
    for (int i = 0; i < NEL; i++) sp_mem[i] = BW'(i + 1);
    busy_polls = 5;
    do_job(16'h1234, 0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_src();
    randomize_data();
    busy_polls = 2;
    do_job(16'($urandom), 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    randomize_data();
    busy_polls = 10;
    do_job(16'($urandom), 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 8; j++) begin
      randomize_data();
      busy_polls = $urandom_range(0, 6);
      do_job(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_job();
    int fed, wsize;
    randomize_data();
    busy_polls = 1;
    @(negedge clk_i);
    job_valid_i = 1'b1; job_ctrl_i = 16'hBEEF;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    feed_rows(NROWS - 1, 0, fed);
    src_valid_i = 1'b1; src_data_i = rows[NROWS - 1];
    #2 rst_ni = 1'b0;
    #1 wsize = wr_q.size();
    total++;
    if (write_enable_o !== 1'b0 || job_ready_o !== 1'b1 || busy_o !== 1'b0 || address_o !== '0 || src_ready_o !== 1'b0) begin
      bad++; $display("FAIL midjob_reset we=%b ready=%b busy=%b addr=%h srdy=%b want 0/1/0/0/0",
                      write_enable_o, job_ready_o, busy_o, address_o, src_ready_o);
    end
    repeat (3) @(negedge clk_i);
    total++;
    if (wr_q.size() != wsize) begin bad++; $display("FAIL midjob_no_write got=%0d want=0", wr_q.size() - wsize); end
    src_valid_i = 1'b0;
    rst_ni = 1'b1;
    randomize_data();
    busy_polls = 3;
    do_job(16'($urandom), 0, 1, 1'b0, 1'b0);
  endtask

`ifdef MATMUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int fed, n, wbase;
    bit saw_res = 1'b0;
    randomize_data();
    busy_polls = 100000;
    wbase = wr_q.size();
    @(negedge clk_i);
    job_valid_i = 1'b1; job_ctrl_i = 16'h00F0;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    feed_rows(NROWS, 0, fed);
    n = 0;
    while (error_o !== 1'b1 && n < 200) begin
      if (res_valid_o) saw_res = 1'b1;
      @(negedge clk_i); n++;
    end
    total++;
    if (error_o !== 1'b1) begin
      bad++; $display("FAIL timeout_error got=%b want=1", error_o);
    end else begin
      total++;
      if (slave_reads != TMO) begin bad++; $display("FAIL timeout_polls got=%0d want=%0d", slave_reads, TMO); end
      total++;
      if (write_enable_o !== 1'b1 || address_o !== '0 || data_o !== '0) begin
        bad++; $display("FAIL abort_write we=%b addr=%h data=%h want 1/0/0", write_enable_o, address_o, data_o);
      end
      total++;
      if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        bad++; $display("FAIL abort_idle ready=%b busy=%b want 1/0", job_ready_o, busy_o);
      end
      @(negedge clk_i);
      total++;
      if (error_o !== 1'b0) begin bad++; $display("FAIL error_pulse got=%b want=0", error_o); end
      total++;
      if (saw_res || res_valid_o !== 1'b0) begin bad++; $display("FAIL abort_no_results got=1 want=0"); end
      total++;
      if (wr_q.size() != wbase + NROWS + 2) begin
        bad++; $display("FAIL abort_wr_count got=%0d want=%0d", wr_q.size() - wbase, NROWS + 2);
      end
    end
  endtask
`endif

  initial begin
    job_valid_i = 1'b0; job_ctrl_i = '0; src_valid_i = 1'b0; src_data_i = '0; res_ready_i = 1'b0;
    for (int i = 0; i < NEL; i++) sp_mem[i] = '0;
    for (int i = 0; i < NROWS; i++) rows[i] = '0;
    test_reset();
    test_directed();
    test_toggle_src();
    test_ignored_inputs();
    test_random_jobs();
    test_reset_mid_job();
`ifdef MATMUL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
